// File: rtl/glb_stream_arb_pkg.sv
// Shared types and sizing helpers for the GLB stream arbiter and other GLB schedulers.
package glb_stream_arb_pkg;

   // Arbiter control state: IDLE spends one bubble cycle choosing a source, BURST passes it through.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int num_req);
      return (num_req <= 1) ? 1 : $clog2(num_req);
   endfunction

   // Width of the per-grant beat counter, which only has to hold 0 .. max_burst-1.
   function automatic int burst_cnt_width(input int max_burst);
      return (max_burst <= 1) ? 1 : $clog2(max_burst);
   endfunction

endpackage

// File: rtl/glb_stream_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after base wins, wrapping.
module rr_pick
   import glb_stream_arb_pkg::*;
#(
   parameter  int N     = 4,
   localparam int IDX_W = id_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] base,
   output logic             any_req,
   output logic [IDX_W-1:0] winner
);

   // Scan offsets from farthest to nearest so the nearest requester is the last one written.
   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop, so no path leaves a value held and no latch is inferred.
      any_req = 1'b0;
      winner  = '0;
      idx     = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = int'(base) + i;
         if (idx >= N) idx = idx - N;
         if (req[IDX_W'(idx)]) begin
            any_req = 1'b1;
            winner  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/glb_stream_arbiter.sv
// Round-robin, burst-locked arbiter sharing one valid/ready GLB-to-fabric write stream
// among NUM_REQ sources. The granted source is passed through combinationally; choosing
// a new source always costs one idle cycle.
module glb_stream_arbiter
   import glb_stream_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 17,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   output logic                        out_last,
   input  logic                        out_ready,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy,
   output logic [CNT_W-1:0]            beat_count
);

   localparam int                ID_W    = id_width(NUM_REQ);
   localparam int                BC_W    = burst_cnt_width(MAX_BURST);
   localparam logic [BC_W-1:0]   BC_LAST = BC_W'(MAX_BURST - 1);
   localparam logic [ID_W-1:0]   ID_MAX  = ID_W'(NUM_REQ - 1);

   arb_state_e        state_q,     state_d;
   logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [ID_W-1:0]   grant_q,     grant_d;
   logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
   logic [CNT_W-1:0]  beat_cnt_q,  beat_cnt_d;

   logic [DATA_W-1:0] data_arr [NUM_REQ];
   logic              any_req;
   logic [ID_W-1:0]   pick_id;
   logic              in_burst;
   logic              handshake;

   rr_pick #(
      .N (NUM_REQ)
   ) u_rr_pick (
      .req     (req_valid),
      .base    (rr_ptr_q),
      .any_req (any_req),
      .winner  (pick_id)
   );

   // Unpack the flat source bus into one word per requester.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         data_arr[i] = req_data[i*DATA_W +: DATA_W];
      end
   end

   // Pass-through from the granted source; flush silences the stream in the same cycle.
   always_comb begin
      in_burst  = (state_q == BURST) && !flush;
      out_valid = in_burst && req_valid[grant_q];
      out_data  = in_burst ? data_arr[grant_q] : '0;
      out_last  = in_burst && (req_last[grant_q] || (burst_cnt_q == BC_LAST));
      req_ready = '0;
      if (in_burst) req_ready[grant_q] = out_ready;
      handshake = out_valid && out_ready;
   end

   // Next-state: flush clears everything, IDLE arbitrates, BURST counts beats until last or the cap.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      if (flush) begin
         state_d     = IDLE;
         rr_ptr_d    = '0;
         burst_cnt_d = '0;
         beat_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_d = pick_id;
                  state_d = BURST;
               end
            end
            BURST: begin
               if (handshake) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
                  if (out_last) begin
                     state_d     = IDLE;
                     rr_ptr_d    = (grant_q == ID_MAX) ? '0 : grant_q + 1'b1;
                     burst_cnt_d = '0;
                  end else begin
                     burst_cnt_d = burst_cnt_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // State registers with synchronous reset taking priority over flush.
   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign grant_id   = grant_q;
   assign busy       = (state_q == BURST);
   assign beat_count = beat_cnt_q;

endmodule

// File: doc/glb_stream_arbiter.md
Name: glb_stream_arbiter

Overview:
- Shares one 17-bit valid/ready GLB-to-fabric write stream among NUM_REQ streaming sources, such as per-tile GLB write engines.
- Grants are round-robin and burst-locked. A grant holds until the source signals last or MAX_BURST beats have transferred.
- Flush aborts any burst and returns the block to idle, matching the fabric flush sequence.
- Sits between the GLB stream sources and a single fabric IO tile input.

Parameters:
NUM_REQ, 4, number of requesting streams (2..8)
DATA_W, 17, stream word width (16 data + 1 control bit)
MAX_BURST, 16, maximum beats per grant before forced rearbitration (>=1)
CNT_W, 32, width of the transferred-beat status counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  synchronous abort/clear, active-high
req_data  input  NUM_REQ*DATA_W  packed source data, requester i at [i*DATA_W +: DATA_W]
req_valid  input  NUM_REQ  source valid
req_last  input  NUM_REQ  source marks current beat as last of its burst
req_ready  output  NUM_REQ  ready back to sources
out_data  output  DATA_W  arbitrated stream data
out_valid  output  1  arbitrated stream valid
out_last  output  1  last beat of current grant
out_ready  input  1  downstream ready
grant_id  output  $clog2(NUM_REQ)  currently granted requester
busy  output  1  high while in BURST state
beat_count  output  CNT_W  total handshakes since reset/flush, wraps at 2^CNT_W

Behaviour:
- Reset: all of the following values hold in the cycle after rst is sampled high:
  - state=IDLE, rr pointer=0, grant_id=0, burst counter=0, beat_count=0.
  - out_valid=0, out_last=0, out_data=0, req_ready=0, busy=0.
- States:
  - IDLE: all outputs are quiescent (out_valid=0, req_ready=0).
    - If any req_valid is high, pick the first requester at or after the rr pointer (wrapping).
    - Register it as grant_id and go to BURST.
    - Arbitration costs exactly 1 bubble cycle: req_valid high at edge t gives out_valid earliest in cycle t+1.
  - BURST: combinational pass-through from the granted requester g.
    - out_data=req_data[g], out_valid=req_valid[g], req_ready[g]=out_ready; all other req_ready=0.
    - Handshake = out_valid & out_ready. Each handshake increments the burst counter and beat_count.
    - out_last = req_last[g] | (burst counter == MAX_BURST-1).
    - A handshake with out_last=1 ends the burst: go to IDLE, rr pointer = (g+1) mod NUM_REQ, burst counter = 0.
- Lock: if the granted source drops valid mid-burst, the grant is held. out_valid=0 and there is no rearbitration until that source completes.
- Fairness: the pointer advances only past the served requester. With all requesters valid and single-beat bursts, service order is 0,1,2,3,0,...
- Flush:
  - In any state, flush high forces, in the same cycle, out_valid=0 and req_ready=0 (no handshake can occur).
  - At the next edge: state=IDLE, rr pointer=0, burst counter=0, beat_count=0.
  - The block stays in IDLE while flush is high.
- Precedence: rst over flush over normal operation.
- Simultaneous events: a burst-ending handshake in the same cycle as a new req_valid elsewhere is served by IDLE on the next cycle; there are no back-to-back grants without the bubble.
- MAX_BURST=1: every beat ends a grant.
- Data is not registered. out_data is don't-care when out_valid=0 but must be 0 in IDLE.

Decomposition:
- Package glb_stream_arb_pkg:
  - state enum {IDLE, BURST}
  - localparam ID_W=$clog2(NUM_REQ) helper function
  - burst counter width function clog2(MAX_BURST)
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, base pointer.
  - Outputs: any_req, winner index.
  - Reusable by other GLB schedulers.

Test Plan:
- Reset: hold rst for 2 cycles with all req_valid=1 -> out_valid=0, req_ready=0000, beat_count=0, grant_id=0 the cycle after; first out_valid 2 cycles after rst drops.
- Round robin: all 4 valid, each sends 1-beat bursts with last=1, out_ready=1 -> grant_id sequence 0,1,2,3,0 with one idle cycle between beats; beat_count=5 after 5 grants.
- Burst cap: MAX_BURST=16, req 2 streams 40 words with last never set, req 0 valid -> 16 beats from 2, then req 0, then req 2 resumes; out_last=1 on beats 16 and 32.
- Backpressure/lock: granted req 1 sends 3 words with out_ready toggling 1,0,0,1 and req_valid gap of 2 cycles -> data order preserved, no other req_ready asserted, grant_id stays 1 until last.
- Flush mid-burst: flush pulsed 1 cycle during beat 5 of a burst -> zero handshakes that cycle, next cycle busy=0, beat_count=0, pointer=0 so req 0 wins next arbitration.
- Backlog: sources 0x0001..0x0004 queued on req 3 with MAX_BURST=4, out_ready always 1 -> out_data 0x0001..0x0004 in 4 consecutive cycles, out_last on 0x0004, busy falls the following cycle.
